// File: rtl/snes_controller_poller_if.sv
// Host- and pad-side signals of snes_controller_poller grouped into one port bundle.
// SNES_CONTROLLER_EDGE_DETECT_EN adds the pressed/released strobe words.
interface snes_controller_poller_if #(
    parameter int NUM_CONTROLLERS = 4
);
    logic                          start_fetch_i;
    logic                          snes_mode_i;
    logic                          busy_o;
    logic                          valid_o;
    logic                          controller_clk_o;
    logic                          controller_latch_o;
    logic [NUM_CONTROLLERS-1:0]    controller_serial_LIST_ni;
    logic [16*NUM_CONTROLLERS-1:0] data_LIST_o;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
    logic [16*NUM_CONTROLLERS-1:0] pressed_LIST_o;
    logic [16*NUM_CONTROLLERS-1:0] released_LIST_o;
`endif

    modport master (
        output start_fetch_i, snes_mode_i, controller_serial_LIST_ni,
        input  busy_o, valid_o, controller_clk_o, controller_latch_o, data_LIST_o
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
        , input pressed_LIST_o, released_LIST_o
`endif
    );

    modport slave (
        input  start_fetch_i, snes_mode_i, controller_serial_LIST_ni,
        output busy_o, valid_o, controller_clk_o, controller_latch_o, data_LIST_o
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
        , output pressed_LIST_o, released_LIST_o
`endif
    );
endinterface

// File: rtl/snes_controller_poller.sv
// Polls NES/SNES pads on a shared clock/latch pair and returns active-high button words.
// Optional SNES_CONTROLLER_EDGE_DETECT_EN adds per-fetch pressed/released strobes.
module snes_controller_poller #(
    parameter int NUM_CONTROLLERS   = 4,
    parameter int CLK_DIV           = 4,
    parameter int LATCH_PULSE_WIDTH = 2,
    parameter int AUTO_POLL_PERIOD  = 0
) (
    input logic                     clk,
    input logic                     rst,
    snes_controller_poller_if.slave bus
);
    localparam int TMAX = (CLK_DIV > LATCH_PULSE_WIDTH) ? CLK_DIV : LATCH_PULSE_WIDTH;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int APW  = (AUTO_POLL_PERIOD > 1) ? $clog2(AUTO_POLL_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_CLK_LO, S_CLK_HI, S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [TW-1:0]                    timer_q, timer_d;
    logic [3:0]                       bit_q, bit_d;
    logic                             snes_q, snes_d;
    logic                             pending_q, pending_d;
    logic [APW-1:0]                   poll_cnt_q, poll_cnt_d;
    logic [NUM_CONTROLLERS-1:0][15:0] shift_q, shift_d;
    logic [16*NUM_CONTROLLERS-1:0]    data_q, data_d;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
    logic [16*NUM_CONTROLLERS-1:0]    pressed_q, pressed_d;
    logic [16*NUM_CONTROLLERS-1:0]    released_q, released_d;
`endif
    logic                             wrap;
    logic                             start;
    logic                             div_last;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        snes_d     = snes_q;
        pending_d  = pending_q;
        poll_cnt_d = poll_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
        pressed_d  = '0;
        released_d = '0;
`endif
        wrap       = 1'b0;
        div_last   = (timer_q == TW'(CLK_DIV - 1));

        if (AUTO_POLL_PERIOD > 0) begin
            if (poll_cnt_q == APW'(AUTO_POLL_PERIOD - 1)) begin
                poll_cnt_d = '0;
                wrap       = 1'b1;
            end else begin
                poll_cnt_d = poll_cnt_q + APW'(1);
            end
        end

        // A wrap in the same cycle as a start is a new request and stays pending.
        start = (state_q == S_IDLE) && (bus.start_fetch_i || pending_q);
        if (wrap) begin
            pending_d = 1'b1;
        end else if (start) begin
            pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    timer_d = '0;
                    bit_d   = '0;
                    snes_d  = bus.snes_mode_i;
                    shift_d = '0;
                end
            end
            S_LATCH: begin
                if (timer_q == TW'(LATCH_PULSE_WIDTH - 1)) begin
                    state_d = S_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SETTLE, S_CLK_HI: begin
                if (div_last) begin
                    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                        shift_d[i][bit_q] = ~bus.controller_serial_LIST_ni[i];
                    end
                    timer_d = '0;
                    if (bit_q == (snes_q ? 4'd15 : 4'd7)) begin
                        state_d = S_DONE;
                        data_d  = shift_d;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
                        pressed_d  = shift_d & ~data_q;
                        released_d = ~shift_d & data_q;
`endif
                    end else begin
                        state_d = S_CLK_LO;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CLK_LO: begin
                if (div_last) begin
                    state_d = S_CLK_HI;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            snes_q     <= 1'b0;
            pending_q  <= 1'b0;
            poll_cnt_q <= '0;
            data_q     <= '0;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
            pressed_q  <= '0;
            released_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            snes_q     <= snes_d;
            pending_q  <= pending_d;
            poll_cnt_q <= poll_cnt_d;
            data_q     <= data_d;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
            pressed_q  <= pressed_d;
            released_q <= released_d;
`endif
        end
    end

    // Shift registers are cleared at every fetch start, so they need no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.busy_o             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.valid_o            = (state_q == S_DONE);
    assign bus.controller_latch_o = (state_q == S_LATCH);
    assign bus.controller_clk_o   = (state_q != S_CLK_LO);
    assign bus.data_LIST_o        = data_q;
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
    assign bus.pressed_LIST_o     = pressed_q;
    assign bus.released_LIST_o    = released_q;
`endif
endmodule

// File: tb/tb_snes_controller_poller.sv
// Bench for snes_controller_poller: a request-driven instance checked cycle by cycle
// against a timing/data model, plus an auto-polling instance checked on its valid schedule.
module tb_snes_controller_poller;
    localparam int D_M = 2;
    localparam int L_M = 2;
    localparam int P_A = 100;
    localparam int LAT_A = 1 + 2 + 4 * 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_a = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    snes_controller_poller_if #(.NUM_CONTROLLERS(4)) m_if ();
    snes_controller_poller_if #(.NUM_CONTROLLERS(2)) a_if ();

    snes_controller_poller #(.NUM_CONTROLLERS(4), .CLK_DIV(D_M), .LATCH_PULSE_WIDTH(L_M),
                             .AUTO_POLL_PERIOD(0)) dut_m (.clk(clk), .rst(rst), .bus(m_if));
    snes_controller_poller #(.NUM_CONTROLLERS(2), .CLK_DIV(4), .LATCH_PULSE_WIDTH(2),
                             .AUTO_POLL_PERIOD(P_A)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if));

    // Pad models: latch reloads the button word, each rising pad clock presents the next bit.
    logic [15:0] btn_m [4];
    logic [15:0] btn_a [2];
    int idx_m = 0;
    int idx_a = 0;

    always @(posedge m_if.controller_latch_o or posedge m_if.controller_clk_o)
        if (m_if.controller_latch_o) idx_m = 0; else idx_m = idx_m + 1;
    always @(posedge a_if.controller_latch_o or posedge a_if.controller_clk_o)
        if (a_if.controller_latch_o) idx_a = 0; else idx_a = idx_a + 1;

    always @* begin
        for (int p = 0; p < 4; p++)
            m_if.controller_serial_LIST_ni[3-p] = (idx_m < 16) ? ~btn_m[p][idx_m[3:0]] : 1'b1;
        for (int p = 0; p < 2; p++)
            a_if.controller_serial_LIST_ni[1-p] = (idx_a < 16) ? ~btn_a[p][idx_a[3:0]] : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Auto-poll instance cycle counter, 0 in the first cycle out of reset.
    int ta = 0;
    always @(posedge clk) if (rst_a) ta <= 0; else ta <= ta + 1;

    // Model state
    int cyc = 0, s = 0, o = 0, b = 0, lat = 0, u = 0;
    bit act = 1'b0, mode = 1'b0, idle = 1'b0;
    logic [63:0] exp_data = '0, exp_words = '0, e_pr = '0, e_rl = '0;
    logic [15:0] w;
    logic e_latch, e_clk, e_busy, e_valid;
    int a_s = P_A, a_nv = P_A + LAT_A, a_idle = 0, a_next = 0;
    int va [$];

    always @(negedge clk) begin
        if (chk_en) begin
            o = cyc - s;
            e_latch = 1'b0; e_clk = 1'b1; e_busy = 1'b0; e_valid = 1'b0;
            e_pr = '0; e_rl = '0;
            b = mode ? 16 : 8;
            lat = 1 + L_M + D_M * (2 * b - 1);
            if (act) begin
                e_latch = (o >= 1 && o <= L_M);
                u = o - (1 + L_M + D_M);
                if (u >= 0 && u < 2 * D_M * (b - 1)) e_clk = ((u % (2 * D_M)) >= D_M);
                e_busy = (o >= 1 && o < lat);
                if (o == lat) begin
                    e_valid = 1'b1;
                    e_pr = exp_words & ~exp_data;
                    e_rl = ~exp_words & exp_data;
                    exp_data = exp_words;
                end
            end
            chk("busy", m_if.busy_o, e_busy);
            chk("valid", m_if.valid_o, e_valid);
            chk("latch", m_if.controller_latch_o, e_latch);
            chk("pad_clk", m_if.controller_clk_o, e_clk);
            chk("data", m_if.data_LIST_o, exp_data);
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
            chk("pressed", m_if.pressed_LIST_o, e_pr);
            chk("released", m_if.released_LIST_o, e_rl);
`endif
            if (rst) begin
                act = 1'b0;
                exp_data = '0;
            end else begin
                idle = !act;
                if (act && o == lat) act = 1'b0;
                if (idle && m_if.start_fetch_i) begin
                    act = 1'b1;
                    s = cyc;
                    mode = m_if.snes_mode_i;
                    for (int p = 0; p < 4; p++) begin
                        w = btn_m[p];
                        if (!mode) w[15:8] = 8'h00;
                        exp_words[16*(3-p) +: 16] = w;
                    end
                end
            end
        end
        cyc++;

        if (chk_en && !rst_a) begin
            chk("auto_valid", a_if.valid_o, (ta == a_nv));
            if (ta == a_nv) begin
                chk("auto_data", a_if.data_LIST_o, {btn_a[0], btn_a[1]});
                va.push_back(ta);
                a_idle = a_nv + 1;
                a_next = (a_s / P_A + 1) * P_A;
                a_s = (a_next > a_idle) ? a_next : a_idle;
                a_nv = a_s + LAT_A;
            end
        end
    end

    // Pulse a start for one cycle, then wait (bounded) for valid; returns cycles from start.
    task automatic do_fetch(input bit snes, output int n);
        @(posedge clk); #1;
        m_if.start_fetch_i = 1'b1;
        m_if.snes_mode_i = snes;
        @(posedge clk); #1;
        m_if.start_fetch_i = 1'b0;
        n = 1;
        while (!m_if.valid_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int n_lat, nv;
    logic [15:0] v;

    initial begin
        m_if.start_fetch_i = 1'b0;
        m_if.snes_mode_i = 1'b0;
        a_if.start_fetch_i = 1'b0;
        a_if.snes_mode_i = 1'b1;
        for (int p = 0; p < 4; p++) btn_m[p] = 16'h0000;
        btn_a[0] = 16'hC3A5;
        btn_a[1] = 16'h5A0F;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_a = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", m_if.busy_o, 1'b0);
        chk("reset_clk", m_if.controller_clk_o, 1'b1);
        chk("reset_data", m_if.data_LIST_o, 64'h0);

        // NES read: upper pad bits must be masked off
        for (int p = 0; p < 4; p++) btn_m[p] = 16'hFFA5;
        do_fetch(1'b0, n_lat);
        chk("nes_latency", n_lat, 33);
        chk("nes_data", m_if.data_LIST_o, {4{16'h00A5}});

        // SNES read
        btn_m[0] = 16'h0001; btn_m[1] = 16'h8000; btn_m[2] = 16'hFFFF; btn_m[3] = 16'h1234;
        do_fetch(1'b1, n_lat);
        chk("snes_latency", n_lat, 65);
        chk("snes_data", m_if.data_LIST_o, {16'h0001, 16'h8000, 16'hFFFF, 16'h1234});

        // Pad 0 walking ones, then random words
        for (int i = 0; i < 22; i++) begin
            v = (i < 16) ? (16'h0001 << i) : 16'($urandom);
            btn_m[0] = v; btn_m[1] = ~v; btn_m[2] = 16'($urandom); btn_m[3] = v ^ 16'h5555;
            do_fetch(1'b1, n_lat);
            chk("sweep_pad0", m_if.data_LIST_o[63:48], v);
        end

        // All pressed in NES mode after SNES reads
        for (int p = 0; p < 4; p++) btn_m[p] = 16'hFFFF;
        do_fetch(1'b0, n_lat);
        chk("nes_all", m_if.data_LIST_o, {4{16'h00FF}});

        // Starts while busy are dropped
        @(posedge clk); #1;
        m_if.start_fetch_i = 1'b1;
        m_if.snes_mode_i = 1'b1;
        nv = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            m_if.start_fetch_i = (c == 5 || c == 20);
            if (m_if.valid_o) nv++;
        end
        m_if.start_fetch_i = 1'b0;
        chk("busy_start_ignored", nv, 1);

        // Reset in the middle of a fetch
        for (int p = 0; p < 4; p++) btn_m[p] = 16'h0F0F;
        @(posedge clk); #1;
        m_if.start_fetch_i = 1'b1;
        m_if.snes_mode_i = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            m_if.start_fetch_i = 1'b0;
            if (c == 15) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_latch", m_if.controller_latch_o, 1'b0);
        chk("abort_clk", m_if.controller_clk_o, 1'b1);
        chk("abort_busy", m_if.busy_o, 1'b0);
        chk("abort_data", m_if.data_LIST_o, 64'h0);
        btn_m[0] = 16'hBEEF; btn_m[1] = 16'h0102; btn_m[2] = 16'h8001; btn_m[3] = 16'h7FFE;
        do_fetch(1'b1, n_lat);
        chk("after_abort_data", m_if.data_LIST_o, {16'hBEEF, 16'h0102, 16'h8001, 16'h7FFE});

        // Press/release words across two fetches
        for (int p = 0; p < 4; p++) btn_m[p] = 16'h0003;
        do_fetch(1'b1, n_lat);
        for (int p = 0; p < 4; p++) btn_m[p] = 16'h0006;
        do_fetch(1'b1, n_lat);
        chk("edge_data", m_if.data_LIST_o, {4{16'h0006}});
`ifdef SNES_CONTROLLER_EDGE_DETECT_EN
        chk("edge_pressed", m_if.pressed_LIST_o, {4{16'h0004}});
        chk("edge_released", m_if.released_LIST_o, {4{16'h0001}});
        @(posedge clk); #1;
        chk("edge_pressed_clear", m_if.pressed_LIST_o, 64'h0);
        chk("edge_released_clear", m_if.released_LIST_o, 64'h0);
`endif
        repeat (5) @(posedge clk);
        #1;

        // Auto-poll schedule: first wrap fetch, then a wrap deferred past a busy fetch
        chk("auto_first_valid", (va.size() > 0) ? va[0] : -1, 227);
        chk("auto_second_valid", (va.size() > 1) ? va[1] : -1, 355);
        chk("auto_valid_count", (va.size() >= 10), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
